// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with enable, polarity control
// and an auto-scan mode that walks the active line with a fixed dwell.
module decoder_scan_nto2n #(
  parameter int N          = 2,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  output logic [(1<<N)-1:0] dout,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int OUTS = 1 << N;
  localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   CMAX = CW'(DWELL - 1);
  localparam logic [OUTS-1:0] OFF  = {OUTS{(ACTIVE_LOW != 0)}};

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  step;
  logic          last;

  assign step = idx + 1'b1;
  assign last = (idx == {N{1'b1}});

  // XOR with OFF turns the one-hot pattern into one-cold when inverted.
  function automatic logic [OUTS-1:0] line(input logic [N-1:0] s);
    logic [OUTS-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v ^ OFF;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dout  <= OFF;
      idx   <= '0;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else if (!en) begin
      state <= IDLE;
      dout  <= OFF;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else if (!mode) begin
      state <= DIRECT;
      dout  <= line(sel);
      idx   <= sel;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        SCAN: begin
          if (cnt == CMAX) begin
            cnt  <= '0;
            idx  <= step;
            dout <= line(step);
            wrap <= last;
          end else begin
            cnt  <= cnt + 1'b1;
            wrap <= 1'b0;
          end
        end
        default: begin
          // Entry loads the start line; wrap only marks an increment.
          state <= SCAN;
          dout  <= line(sel);
          idx   <= sel;
          wrap  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Directed scoreboard bench: main decoder (DWELL=3) plus an
// inverted-polarity, single-cycle-dwell instance on shared inputs.
module tb_decoder_scan_nto2n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] sel = '0;
  logic [3:0] dout_a, dout_b;
  logic [1:0] idx_a, idx_b;
  logic       wrap_a, wrap_b;

  int n_chk = 0;
  int n_fail = 0;
  int step_no = 0;

  typedef struct {
    int         id;
    logic       alt;
    logic [3:0] dout;
    logic [1:0] idx;
    logic       wrap;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  decoder_scan_nto2n #(.N(2), .DWELL(3), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .dout(dout_a), .idx(idx_a), .wrap(wrap_a)
  );

  decoder_scan_nto2n #(.N(2), .DWELL(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .dout(dout_b), .idx(idx_b), .wrap(wrap_b)
  );

  task automatic check();
    exp_t e;
    logic [3:0] d;
    logic [1:0] i;
    logic       w;
    e = q.pop_front();
    d = e.alt ? dout_b : dout_a;
    i = e.alt ? idx_b : idx_a;
    w = e.alt ? wrap_b : wrap_a;
    n_chk += 3;
    assert (d === e.dout) else begin
      n_fail++;
      $error("FAIL dout step=%0d alt=%0b got=%b exp=%b",
             e.id, e.alt, d, e.dout);
    end
    assert (i === e.idx) else begin
      n_fail++;
      $error("FAIL idx step=%0d alt=%0b got=%0d exp=%0d",
             e.id, e.alt, i, e.idx);
    end
    assert (w === e.wrap) else begin
      n_fail++;
      $error("FAIL wrap step=%0d alt=%0b got=%b exp=%b",
             e.id, e.alt, w, e.wrap);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic m,
                     input logic [1:0] s, input logic alt,
                     input logic [3:0] d, input logic [1:0] i,
                     input logic w);
    @(negedge clk);
    rst  = r;
    en   = e;
    mode = m;
    sel  = s;
    step_no++;
    q.push_back('{id: step_no, alt: alt, dout: d, idx: i, wrap: w});
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    logic [1:0] ln;
    // reset held with en/mode high; both polarities
    cyc(1, 1, 1, 0, 0, 4'b0000, 0, 0);
    cyc(1, 1, 1, 0, 1, 4'b1111, 0, 0);
    cyc(0, 1, 1, 0, 0, 4'b0001, 0, 0);
    cyc(0, 1, 1, 0, 0, 4'b0001, 0, 0);
    cyc(0, 0, 1, 0, 0, 4'b0000, 0, 0);
    // direct decode, one cycle latency from IDLE onward
    cyc(0, 1, 0, 0, 0, 4'b0001, 0, 0);
    cyc(0, 1, 0, 1, 0, 4'b0010, 1, 0);
    cyc(0, 1, 0, 2, 0, 4'b0100, 2, 0);
    cyc(0, 1, 0, 3, 0, 4'b1000, 3, 0);
    // scan from line 2; sel changes after entry are ignored
    cyc(0, 1, 1, 2, 0, 4'b0100, 2, 0);
    for (int k = 1; k <= 22; k++) begin
      ln = 2'((2 + k / 3) % 4);
      cyc(0, 1, 1, 2'(k), 0, 4'b0001 << ln, ln,
          (k == 6 || k == 18));
    end
    // disable mid-dwell on line 1, then re-enter on line 3
    cyc(0, 0, 1, 0, 0, 4'b0000, 1, 0);
    cyc(0, 1, 1, 3, 0, 4'b1000, 3, 0);
    cyc(0, 1, 1, 0, 0, 4'b1000, 3, 0);
    cyc(0, 1, 1, 0, 0, 4'b1000, 3, 0);
    cyc(0, 1, 1, 0, 0, 4'b0001, 0, 1);
    // mode switch to direct mid-scan
    cyc(0, 1, 0, 0, 0, 4'b0001, 0, 0);
    cyc(0, 1, 0, 0, 0, 4'b0001, 0, 0);
    cyc(0, 1, 0, 2, 0, 4'b0100, 2, 0);
    // back to scan, then reset mid-dwell
    cyc(0, 1, 1, 1, 0, 4'b0010, 1, 0);
    cyc(0, 1, 1, 1, 0, 4'b0010, 1, 0);
    cyc(1, 1, 1, 1, 0, 4'b0000, 0, 0);
    cyc(1, 1, 1, 0, 1, 4'b1111, 0, 0);
    // inverted polarity, one-cycle dwell
    cyc(0, 1, 1, 0, 1, 4'b1110, 0, 0);
    cyc(0, 1, 1, 0, 1, 4'b1101, 1, 0);
    cyc(0, 1, 1, 0, 1, 4'b1011, 2, 0);
    cyc(0, 1, 1, 0, 1, 4'b0111, 3, 0);
    cyc(0, 1, 1, 0, 1, 4'b1110, 0, 1);
    cyc(0, 1, 1, 0, 1, 4'b1101, 1, 0);
    cyc(0, 0, 1, 0, 1, 4'b1111, 1, 0);
    n_chk++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_left got=%0d exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
